// File: rtl/trng_scheduler.sv
// Round-robin scheduler that hands single random words from a shared generator to N_REQ requesters.
// Optional health test on captured words is compiled in by defining TRNG_SCHEDULER_HEALTH_EN.
module trng_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 512,
    parameter int TIMEOUT = 1100
) (
    input  logic              LOCAL_SCLK,
    input  logic              RST,
    input  logic [N_REQ-1:0]  REQ,
    input  logic              RNG_VALID,
    input  logic [WIDTH-1:0]  RNG_DATA,
    output logic              RNG_RUN,
    output logic [N_REQ-1:0]  GNT,
    output logic [WIDTH-1:0]  DOUT,
    output logic              ERR,
    output logic              BUSY
`ifdef TRNG_SCHEDULER_HEALTH_EN
    ,
    output logic [7:0]        REJECT_CNT
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HARVEST,
        ST_CHECK,
        ST_DELIVER
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic              err_q, err_d;

    logic [PW-1:0]     pick;
    logic [PW-1:0]     idx;
    logic              found;
    logic [10:0]       cnt_inc;

`ifdef TRNG_SCHEDULER_HEALTH_EN
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [7:0]        rej_q, rej_d;
    logic              word_ok;
`endif

    // Round-robin search starts one past the last granted requester.
    always_comb begin
        pick  = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = PW'((int'(ptr_q) + i) % N_REQ);
            if (!found && REQ[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign cnt_inc = cnt_q + 11'd1;

`ifdef TRNG_SCHEDULER_HEALTH_EN
    assign word_ok = (cap_q != '0) && (cap_q != '1) && (cap_q != prev_q);
`endif

    always_ff @(posedge LOCAL_SCLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(N_REQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
`ifdef TRNG_SCHEDULER_HEALTH_EN
            prev_q  <= '0;
            rej_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
`ifdef TRNG_SCHEDULER_HEALTH_EN
            prev_q  <= prev_d;
            rej_q   <= rej_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        err_d   = err_q;
`ifdef TRNG_SCHEDULER_HEALTH_EN
        prev_d  = prev_q;
        rej_d   = rej_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|REQ && !err_q) begin
                    state_d = ST_HARVEST;
                    win_d   = pick;
                    cnt_d   = '0;
                end
            end
            ST_HARVEST: begin
                if (RNG_VALID) begin
                    cap_d   = RNG_DATA;
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else if (cnt_inc == 11'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            ST_CHECK: begin
`ifdef TRNG_SCHEDULER_HEALTH_EN
                if (word_ok) begin
                    prev_d  = cap_q;
                    state_d = ST_DELIVER;
                end else begin
                    if (rej_q != 8'hFF) begin
                        rej_d = rej_q + 8'd1;
                    end
                    cnt_d   = '0;
                    state_d = ST_HARVEST;
                end
`else
                state_d = ST_DELIVER;
`endif
            end
            ST_DELIVER: begin
                // A dropped request forfeits the word and leaves the pointer alone.
                if (REQ[win_q]) begin
                    ptr_d = win_q;
                end
                cap_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        RNG_RUN = (state_q == ST_HARVEST);
        BUSY    = (state_q != ST_IDLE);
        ERR     = err_q;
        GNT     = '0;
        DOUT    = '0;
        if ((state_q == ST_DELIVER) && REQ[win_q] && !RST) begin
            GNT[win_q] = 1'b1;
            DOUT       = cap_q;
        end
    end

`ifdef TRNG_SCHEDULER_HEALTH_EN
    assign REJECT_CNT = rej_q;
`endif

endmodule

// File: tb/tb_trng_scheduler.sv
// Bench for trng_scheduler: random request patterns and generator timing against a round-robin model.
module tb_trng_scheduler;
    localparam int N  = 4;
    localparam int W  = 512;
    localparam int TO = 1100;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          vld;
    logic [W-1:0]  data;
    logic          run;
    logic [N-1:0]  gnt;
    logic [W-1:0]  dout;
    logic          err;
    logic          busy;
`ifdef TRNG_SCHEDULER_HEALTH_EN
    logic [7:0]    rej;
`endif

    always #5 clk = ~clk;

    trng_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .LOCAL_SCLK (clk),
        .RST        (rst),
        .REQ        (req),
        .RNG_VALID  (vld),
        .RNG_DATA   (data),
        .RNG_RUN    (run),
        .GNT        (gnt),
        .DOUT       (dout),
        .ERR        (err),
        .BUSY       (busy)
`ifdef TRNG_SCHEDULER_HEALTH_EN
        ,
        .REJECT_CNT (rej)
`endif
    );

    typedef struct {
        int           idx;
        logic [W-1:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ptr    = N - 1;   // model: last granted requester

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] pat);
        for (int i = 1; i <= N; i++) begin
            if (pat[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Monitor: every grant must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (gnt !== '0) begin
                check("gnt_onehot", W'($onehot(gnt)), 1);
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got GNT=%b expected none", gnt);
                end else begin
                    e = sb.pop_front();
                    check("gnt_idx", W'(gnt), W'(N'(1) << e.idx));
                    check("dout", dout, e.word);
                end
            end else begin
                check("dout_zero", dout, '0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // One request round; caller guarantees the DUT is in IDLE.
    task automatic txn(input logic [N-1:0] pat, input int fill, input logic [W-1:0] word, input bit drop);
        int win;
        int k;
        bit seen;
        req  = pat;
        win  = rr_pick(pat);
        k    = 0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            k++;
            seen = run;
        end
        check("harvest_start", W'(k), 1);
        if (drop) req = '0;
        repeat (fill) begin
            tick();
            k++;
        end
        vld  = 1'b1;
        data = word;
        if (!drop) begin
            sb.push_back('{win, word});
            ptr = win;
        end
        tick();
        k++;
        vld  = 1'b0;
        data = rand_word();
        if (!drop) begin
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                if (gnt !== '0) seen = 1'b1;
                else begin
                    tick();
                    k++;
                end
            end
            check("latency", W'(k), W'(3 + fill));
            tick();
        end else begin
            for (int c = 0; c < 8 && busy; c++) tick();
        end
        check("idle_after", W'(busy), 0);
        req = '0;
    endtask

    task automatic reset_chk(input string name);
        check({name, "_gnt"}, W'(gnt), 0);
        check({name, "_dout"}, dout, '0);
        check({name, "_run"}, W'(run), 0);
        check({name, "_err"}, W'(err), 0);
        check({name, "_busy"}, W'(busy), 0);
    endtask

    initial begin
        int  n;
        bit  any_busy;
        bit  seen;
        rst  = 1'b1;
        req  = '0;
        vld  = 1'b0;
        data = '0;
        tick();
        tick();
        reset_chk("reset");
        rst = 1'b0;
        tick();

        txn(4'b0001, 513, {16{32'hA5A5A5A5}}, 1'b0);

        txn(4'b1111, $urandom_range(0, 5), rand_word(), 1'b0);
        txn(4'b1110, $urandom_range(0, 5), rand_word(), 1'b0);
        txn(4'b1100, $urandom_range(0, 5), rand_word(), 1'b0);
        txn(4'b1000, $urandom_range(0, 5), rand_word(), 1'b0);

        txn(4'b0100, 3, rand_word(), 1'b1);
        txn(4'b0110, 2, rand_word(), 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                vld  = 1'b1;
                data = rand_word();
                tick();
                vld  = 1'b0;
            end
            txn(N'($urandom_range(1, 15)), $urandom_range(0, 12), rand_word(), $urandom_range(0, 5) == 0);
        end

`ifdef TRNG_SCHEDULER_HEALTH_EN
        begin
            int           win;
            int           before;
            logic [W-1:0] w1234;
            w1234  = W'(16'h1234);
            before = int'(rej);
            req    = 4'b0001;
            win    = rr_pick(req);
            seen   = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                seen = run;
            end
            vld  = 1'b1;
            data = '0;
            tick();
            vld  = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                seen = run;
            end
            check("health_reharvest", W'(seen), 1);
            sb.push_back('{win, w1234});
            ptr  = win;
            vld  = 1'b1;
            data = w1234;
            tick();
            vld  = 1'b0;
            for (int c = 0; c < 8 && gnt === '0; c++) tick();
            tick();
            req = '0;
            check("reject_cnt", W'(rej), W'(before + 1));
        end
`endif

        req  = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = run;
        end
        repeat (5) tick();
        rst = 1'b1;
        req = '0;
        tick();
        reset_chk("mid_rst");
        rst = 1'b0;
        ptr = N - 1;
        tick();
        txn(4'b1111, 1, rand_word(), 1'b0);

        req  = 4'b0001;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = run;
        end
        n = 0;
        while (run && n < 2000) begin
            n++;
            tick();
        end
        check("timeout_cycles", W'(n), W'(TO));
        check("timeout_err", W'(err), 1);
        check("timeout_run", W'(run), 0);
        any_busy = 1'b0;
        repeat (20) begin
            tick();
            any_busy |= busy;
        end
        check("err_blocks_req", W'(any_busy), 0);
        check("err_sticky", W'(err), 1);
        req = '0;
        rst = 1'b1;
        tick();
        check("err_cleared", W'(err), 0);
        rst = 1'b0;
        tick();

        check("sb_empty", W'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/trng_scheduler.md
TRNG_SCHEDULER -- requirements
Module: trng_scheduler

Interface
REQ-001 Reset RST SHALL be synchronous, active-high; clock LOCAL_SCLK; all state SHALL update on posedge LOCAL_SCLK only.
REQ-002 Parameter N_REQ, default 4, number of requesters, legal range 2..8.
REQ-003 Parameter WIDTH, default 512, random word width.
REQ-004 Parameter TIMEOUT, default 1100, maximum cycles in HARVEST before an error is flagged, legal range 16..2047.
REQ-005 LOCAL_SCLK  in  1  clock.
REQ-006 RST  in  1  synchronous reset, active-high.
REQ-007 REQ  in  N_REQ  level request per requester; held high until that requester's GNT pulse.
REQ-008 RNG_VALID  in  1  generator word-ready flag.
REQ-009 RNG_DATA  in  WIDTH  generator word; sampled only when RNG_VALID=1.
REQ-010 RNG_RUN  out  1  enables generator bit collection; high only in HARVEST.
REQ-011 GNT  out  N_REQ  one-hot, one-cycle grant pulse; DOUT valid in the same cycle.
REQ-012 DOUT  out  WIDTH  delivered random word; zero whenever GNT=0.
REQ-013 ERR  out  1  sticky timeout flag.
REQ-014 BUSY  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, HARVEST, CHECK and DELIVER.
REQ-016 IDLE -> HARVEST SHALL occur when any REQ bit is high and ERR=0; the winner SHALL be latched at this transition.
REQ-017 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod N_REQ; pointer reset value is N_REQ-1, so requester 0 wins first.
REQ-018 The latched winner SHALL stay fixed until DELIVER, even if REQ changes meanwhile.
REQ-019 HARVEST: RNG_RUN=1 and an 11-bit wait counter SHALL increment each cycle.
REQ-020 HARVEST -> CHECK SHALL occur on the first cycle with RNG_VALID=1; RNG_DATA SHALL be captured that cycle and the counter cleared.
REQ-021 If the counter reaches TIMEOUT with RNG_VALID=0, the block SHALL set ERR, drop RNG_RUN and return to IDLE without a grant.
REQ-022 CHECK SHALL last one cycle and go to DELIVER, or back to HARVEST per REQ-032.
REQ-023 DELIVER SHALL last one cycle: GNT[winner]=1, DOUT=captured word, pointer=winner, then IDLE.
REQ-024 Each captured word SHALL be delivered at most once; captured words SHALL never be reused or split.
REQ-025 If the winner's REQ has dropped by DELIVER, the word SHALL be discarded, no GNT asserted, and the pointer left unchanged.
REQ-026 RNG_VALID outside HARVEST SHALL be ignored.
REQ-027 Minimum latency: REQ high in IDLE -> GNT = 3 cycles + generator fill time.

Reset
REQ-028 On RST: state=IDLE, GNT=0, DOUT=0, RNG_RUN=0, ERR=0, BUSY=0, counter=0, pointer=N_REQ-1, capture register=0.
REQ-029 RST in any state SHALL abort the current operation; no GNT SHALL be issued in the cycle RST is high.
REQ-030 RST SHALL be the only way to clear ERR.

Configuration
REQ-031 Macro TRNG_SCHEDULER_HEALTH_EN SHALL compile the health test in.
REQ-032 With the macro defined, CHECK SHALL reject words that are all-zero, all-one, or equal to the previous accepted word; on rejection the block SHALL return to HARVEST with the counter cleared and increment an 8-bit saturating output REJECT_CNT (reset 0).
REQ-033 Without the macro, REJECT_CNT SHALL not exist and CHECK SHALL always proceed to DELIVER.

Verification
REQ-034 REQ=4'b0001, RNG_VALID pulses 513 cycles after RNG_RUN with RNG_DATA=512'hA5..A5 -> GNT=4'b0001 for one cycle, DOUT=A5..A5, then BUSY=0.
REQ-035 REQ=4'b1111 held for four words -> grants in order 0,1,2,3, each GNT one-hot, with four distinct words.
REQ-036 REQ=4'b0001, RNG_VALID held low -> ERR=1 after TIMEOUT=1100 cycles, RNG_RUN=0, no GNT; further REQ is ignored until RST.
REQ-037 RST asserted mid-HARVEST -> next cycle all outputs are at reset values and the next grant goes to requester 0.
REQ-038 With TRNG_SCHEDULER_HEALTH_EN: first word all-zero, second word 512'h1234 -> REJECT_CNT=1, GNT delivers 512'h1234.
REQ-039 REQ[2] drops during HARVEST -> no GNT; pointer unchanged; the next requester in round-robin order is served.
